// File: rtl/cdp1802_dma_responder_if.sv
// cdp1802_dma_responder_if
//   Bundles the signals between the DMA/interrupt responder, the CPU core,
//   the display chip and the synchronous RAM.
//   slave  : the responder (consumes requests and CPU signals, drives timing/RAM/DMA outputs)
//   master : the surrounding system (CPU core, display chip, RAM)
//   Signals:
//     ce, dma_out_req, int_req, ie, cpu_sc[1:0], r0_we, r0_din[ADDR_W-1:0], ram_q[7:0]  -> responder
//     ram_rd, ram_a[ADDR_W-1:0], TPA, TPB, SC[1:0], DataOut[7:0], cpu_hold, int_ack,
//     r0[ADDR_W-1:0]                                                               <- responder
interface cdp1802_dma_responder_if #(
  parameter int ADDR_W = 16
);
  logic              ce;
  logic              dma_out_req;
  logic              int_req;
  logic              ie;
  logic [1:0]        cpu_sc;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_din;
  logic [7:0]        ram_q;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_a;
  logic              TPA;
  logic              TPB;
  logic [1:0]        SC;
  logic [7:0]        DataOut;
  logic              cpu_hold;
  logic              int_ack;
  logic [ADDR_W-1:0] r0;

  modport slave (
    input  ce, dma_out_req, int_req, ie, cpu_sc, r0_we, r0_din, ram_q,
    output ram_rd, ram_a, TPA, TPB, SC, DataOut, cpu_hold, int_ack, r0
  );

  modport master (
    output ce, dma_out_req, int_req, ie, cpu_sc, r0_we, r0_din, ram_q,
    input  ram_rd, ram_a, TPA, TPB, SC, DataOut, cpu_hold, int_ack, r0
  );
endinterface

// File: rtl/cdp1802_dma_responder.sv
// cdp1802_dma_responder
//   Machine-cycle sequencer for a CDP1802-style CPU: generates the 8-phase
//   cycle with TPA/TPB, arbitrates DMA-out and interrupt cycles requested by
//   the display chip, fetches DMA bytes from RAM through the R0 pointer and
//   presents them on DataOut.
//   Ports:
//     clk   : system clock, all state changes on its rising edge
//     reset : asynchronous, active-high reset
//     bus   : cdp1802_dma_responder_if.slave (requests, CPU state code, R0
//             write port, RAM port, timing pulses, DMA data, hold/ack)
module cdp1802_dma_responder #(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cdp1802_dma_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_DMA = 2'd1,
    ST_INT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_phase;
  logic [ADDR_W-1:0] r_r0;
  logic [7:0]        r_data_out;
  logic              r_rd_d;
  logic              r_int_ack;
  logic              w_cycle_end;
  logic              w_ram_rd;
  logic [ADDR_W-1:0] w_ram_a;
  logic [1:0]        w_sc;
  logic              w_hold;

  // The only edge on which the machine state may change.
  assign w_cycle_end = bus.ce && (r_phase == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CPU;
    end else if (w_cycle_end) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_CPU;
    w_ram_rd     = 1'b0;
    w_ram_a      = '0;
    w_sc         = bus.cpu_sc;
    w_hold       = 1'b0;

    // DMA wins over INT; an INT cycle is never followed directly by another.
    if (bus.dma_out_req) begin
      w_state_next = ST_DMA;
    end else if (bus.int_req && bus.ie && (r_state != ST_INT)) begin
      w_state_next = ST_INT;
    end

    case (r_state)
      ST_DMA: begin
        w_sc     = 2'b10;
        w_hold   = 1'b1;
        w_ram_a  = r_r0;
        w_ram_rd = (r_phase == 3'd1);
      end
      ST_INT: begin
        w_sc   = 2'b11;
        w_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= '0;
      r_r0       <= '0;
      r_data_out <= '0;
      r_rd_d     <= 1'b0;
      r_int_ack  <= 1'b0;
    end else begin
      if (bus.ce) begin
        r_phase <= r_phase + 3'd1;
      end
      // RAM answers one clk after the read strobe; grab the byte then.
      r_rd_d <= w_ram_rd;
      if (r_rd_d) begin
        r_data_out <= bus.ram_q;
      end
      r_int_ack <= w_cycle_end && (w_state_next == ST_INT);
      // A CPU write overrides the post-DMA increment on the same edge.
      if (bus.r0_we) begin
        r_r0 <= bus.r0_din;
      end else if (w_cycle_end && (r_state == ST_DMA)) begin
        r_r0 <= r_r0 + ADDR_W'(1);
      end
    end
  end

  assign bus.TPA      = (r_phase == 3'd1);
  assign bus.TPB      = (r_phase == 3'd6);
  assign bus.SC       = w_sc;
  assign bus.cpu_hold = w_hold;
  assign bus.int_ack  = r_int_ack;
  assign bus.ram_rd   = w_ram_rd;
  assign bus.ram_a    = w_ram_a;
  assign bus.DataOut  = r_data_out;
  assign bus.r0       = r_r0;

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// tb_cdp1802_dma_responder
//   Directed bench for cdp1802_dma_responder with a cycle-level reference
//   model and a per-cycle compare process, plus literal expectations.
module tb_cdp1802_dma_responder;

  localparam int M_CPU = 0;
  localparam int M_DMA = 1;
  localparam int M_INT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cdp1802_dma_responder_if #(.ADDR_W(16)) bus ();

  cdp1802_dma_responder #(.ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous RAM seen by the DUT.
  logic [7:0] mem [0:65535];
  logic [7:0] ram_q_r = 8'h00;
  always @(posedge clk) if (bus.ram_rd) ram_q_r <= mem[bus.ram_a];
  assign bus.ram_q = ram_q_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a machine cycle is 8 ce-steps; the kind of the next
  // cycle is chosen from the request lines seen at the last step of the
  // current one. A DMA cycle shows mem[R0] from its phase 3 onwards.
  int          m_phase = 0;
  int          m_state = M_CPU;
  logic [15:0] m_r0    = 16'h0;
  logic [7:0]  m_data  = 8'h0;
  bit          m_ack   = 1'b0;

  always @(posedge clk or posedge reset) begin
    int nxt;
    if (reset) begin
      m_phase = 0;
      m_state = M_CPU;
      m_r0    = 16'h0;
      m_data  = 8'h0;
      m_ack   = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (bus.ce) begin
        if (m_phase == 7) begin
          if (bus.dma_out_req) nxt = M_DMA;
          else if (bus.int_req && bus.ie && m_state != M_INT) nxt = M_INT;
          else nxt = M_CPU;
          if (m_state == M_DMA) m_r0 = m_r0 + 16'h1;
          m_ack   = (nxt == M_INT);
          m_state = nxt;
        end
        m_phase = (m_phase + 1) % 8;
      end
      if (bus.r0_we) m_r0 = bus.r0_din;
      if (m_state == M_DMA && m_phase == 3) m_data = mem[m_r0];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0] exp_sc;
    exp_sc = (m_state == M_CPU) ? bus.cpu_sc : (m_state == M_DMA) ? 2'b10 : 2'b11;
    chk("TPA",      bus.TPA,      (m_phase == 1));
    chk("TPB",      bus.TPB,      (m_phase == 6));
    chk("SC",       bus.SC,       exp_sc);
    chk("cpu_hold", bus.cpu_hold, (m_state != M_CPU));
    chk("int_ack",  bus.int_ack,  m_ack);
    chk("r0",       bus.r0,       m_r0);
    chk("DataOut",  bus.DataOut,  m_data);
    chk("ram_rd",   bus.ram_rd,   (m_state == M_DMA && m_phase == 1));
    chk("ram_a",    bus.ram_a,    (m_state == M_DMA) ? m_r0 : 16'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 16) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase actual=%0d required=%0d", m_phase, p);
    end
  endtask

  task automatic load_r0(input logic [15:0] v);
    bus.r0_we  = 1'b1;
    bus.r0_din = v;
    tick();
    bus.r0_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       tpa_hist [1:24];
    logic       tpb_hist [1:24];
    logic [7:0] got [$];
    logic [1:0] sc_seq [0:3];
    int         acks, holds, idx;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'((i + 1) * 8'h11);
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'h3C;
    mem[16'h0200] = 8'h77;

    bus.ce = 1'b1; bus.dma_out_req = 1'b0; bus.int_req = 1'b0; bus.ie = 1'b0;
    bus.cpu_sc = 2'b01; bus.r0_we = 1'b0; bus.r0_din = 16'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_r0", bus.r0, 16'h0);
    chk("rst_dataout", bus.DataOut, 8'h0);
    chk("rst_hold", bus.cpu_hold, 1'b0);
    chk("rst_tpa", bus.TPA, 1'b0);
    chk("rst_sc", bus.SC, 2'b01);
    reset = 1'b0;
    $display("reset released");

    // Free-running timing, no requests
    for (int k = 1; k <= 24; k++) begin
      bus.cpu_sc = 2'($urandom_range(0, 3));
      tick();
      tpa_hist[k] = bus.TPA;
      tpb_hist[k] = bus.TPB;
    end
    for (int k = 1; k <= 24; k++) begin
      chk("tpa_slot", tpa_hist[k], (k == 1 || k == 9 || k == 17));
      chk("tpb_slot", tpb_hist[k], (k == 6 || k == 14 || k == 22));
    end
    tick();
    bus.ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ce_hold_tpa", bus.TPA, 1'b1);
    end
    bus.ce = 1'b1;
    bus.cpu_sc = 2'b01;
    $display("timing run done");

    // Eight back-to-back DMA cycles from 0x0100
    load_r0(16'h0100);
    wait_phase(5);
    bus.dma_out_req = 1'b1;
    for (int k = 0; k < 72; k++) begin
      if (k == 64) bus.dma_out_req = 1'b0;
      tick();
      if (m_state == M_DMA && m_phase == 7) begin
        got.push_back(bus.DataOut);
        $display("DMA byte %0d data=%02h", got.size(), bus.DataOut);
      end
    end
    chk("dma_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("dma_byte", got[i], (i + 1) * 8'h11);
    chk("dma_r0_end", bus.r0, 16'h0108);

    // DMA + INT together: DMA first, then INT, INT never back-to-back
    bus.dma_out_req = 1'b1; bus.int_req = 1'b1; bus.ie = 1'b1;
    repeat (8) tick();
    chk("prio_sc_dma", bus.SC, 2'b10);
    bus.dma_out_req = 1'b0;
    acks = 0; idx = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (bus.int_ack) acks++;
      if (m_phase == 4 && idx < 4) begin
        sc_seq[idx] = bus.SC;
        idx++;
      end
    end
    chk("int_ack_count", acks, 2);
    chk("int_seq0", sc_seq[0], 2'b11);
    chk("int_seq1", sc_seq[1], 2'b01);
    chk("int_seq2", sc_seq[2], 2'b11);
    chk("int_seq3", sc_seq[3], 2'b01);
    bus.int_req = 1'b0;
    $display("dma/int arbitration done acks=%0d", acks);

    // Interrupt masked
    bus.ie = 1'b0; bus.int_req = 1'b1;
    acks = 0; holds = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus.int_ack) acks++;
      if (bus.cpu_hold) holds++;
    end
    chk("masked_ack", acks, 0);
    chk("masked_hold", holds, 0);
    bus.int_req = 1'b0;
    $display("masked interrupt done");

    // R0 wrap at 0xFFFF
    load_r0(16'hFFFF);
    wait_phase(5);
    bus.dma_out_req = 1'b1;
    repeat (3) tick();
    bus.dma_out_req = 1'b0;
    wait_phase(7);
    chk("wrap_sc", bus.SC, 2'b10);
    chk("wrap_byte", bus.DataOut, 8'h5A);
    chk("wrap_r0_pre", bus.r0, 16'hFFFF);
    tick();
    chk("wrap_r0_post", bus.r0, 16'h0000);
    $display("DMA wrap done data=%02h", bus.DataOut);

    // CPU load coinciding with the DMA increment
    wait_phase(5);
    bus.dma_out_req = 1'b1;
    repeat (3) tick();
    bus.dma_out_req = 1'b0;
    wait_phase(7);
    chk("load_byte", bus.DataOut, 8'h3C);
    load_r0(16'h1234);
    chk("load_wins", bus.r0, 16'h1234);
    $display("load vs increment done r0=%04h", bus.r0);

    // Reset in the middle of a DMA cycle
    load_r0(16'h0200);
    wait_phase(5);
    bus.dma_out_req = 1'b1;
    repeat (3) tick();
    wait_phase(4);
    chk("mid_dma_byte", bus.DataOut, 8'h77);
    chk("mid_dma_sc", bus.SC, 2'b10);
    reset = 1'b1;
    #1;
    chk("abort_r0", bus.r0, 16'h0);
    chk("abort_dataout", bus.DataOut, 8'h0);
    chk("abort_hold", bus.cpu_hold, 1'b0);
    chk("abort_sc", bus.SC, 2'b01);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("post_rst_hold", bus.cpu_hold, 1'b0);
    chk("post_rst_tpa", bus.TPA, 1'b1);
    repeat (6) tick();
    chk("post_rst_cpu", bus.cpu_hold, 1'b0);
    tick();
    chk("post_rst_dma", bus.SC, 2'b10);
    bus.dma_out_req = 1'b0;
    repeat (16) tick();
    chk("final_r0", bus.r0, 16'h0001);
    $display("reset abort done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdp1802_dma_responder.md
CDP1802_DMA_RESPONDER -- requirements
Module: cdp1802_dma_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width and R0 width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  clock enable; machine-cycle phase advances only when ce=1.
REQ-005 SHALL have port dma_out_req  input  1  DMA-out request from the display chip, active-high.
REQ-006 SHALL have port int_req  input  1  interrupt request from the display chip, active-high.
REQ-007 SHALL have port ie  input  1  CPU interrupt-enable flag.
REQ-008 SHALL have port cpu_sc  input  2  state code driven by the CPU core during normal cycles.
REQ-009 SHALL have port r0_we  input  1  CPU write strobe for R0.
REQ-010 SHALL have port r0_din  input  ADDR_W  value written to R0.
REQ-011 SHALL have port ram_q  input  8  synchronous RAM read data, valid one clk after ram_rd.
REQ-012 SHALL have port ram_rd  output  1  RAM read enable.
REQ-013 SHALL have port ram_a  output  ADDR_W  RAM address.
REQ-014 SHALL have port TPA  output  1  early timing pulse.
REQ-015 SHALL have port TPB  output  1  late timing pulse.
REQ-016 SHALL have port SC  output  2  current machine-cycle state code.
REQ-017 SHALL have port DataOut  output  8  DMA byte presented to the display chip.
REQ-018 SHALL have port cpu_hold  output  1  stalls the CPU core during DMA/interrupt cycles.
REQ-019 SHALL have port int_ack  output  1  one-clk pulse when an interrupt cycle starts.
REQ-020 SHALL have port r0  output  ADDR_W  current R0 (DMA pointer).

Function
REQ-021 SHALL run a 3-bit phase counter 0..7, incrementing on each ce, wrapping 7->0; one wrap = one machine cycle.
REQ-022 SHALL assert TPA for exactly phase 1 and TPB for exactly phase 6 (qualified only by phase, held while ce=0).
REQ-023 SHALL implement states CPU, DMA, INT; state changes only on the ce edge leaving phase 7.
REQ-024 SHALL select next state at phase-7 exit: dma_out_req=1 -> DMA; else int_req=1 and ie=1 and current state not INT -> INT; else CPU.
REQ-025 DMA SHALL have priority over INT when both requested at the same phase-7 sample.
REQ-026 SHALL allow back-to-back DMA cycles while dma_out_req remains high at each phase-7 sample, no CPU cycle inserted.
REQ-027 SC SHALL equal cpu_sc in CPU, 2'b10 in DMA, 2'b11 in INT.
REQ-028 cpu_hold SHALL be 1 in DMA and INT states, 0 in CPU.
REQ-029 int_ack SHALL pulse for one clk on entry to INT.
REQ-030 In DMA, ram_a SHALL equal R0 and ram_rd SHALL be 1 during phase 1 only; otherwise ram_rd=0.
REQ-031 DataOut SHALL capture ram_q on the clk after the phase-1 read and hold it until the next DMA capture.
REQ-032 R0 SHALL increment by 1 modulo 2^ADDR_W at phase-7 exit of every DMA cycle (max value wraps to 0).
REQ-033 r0_we=1 SHALL load r0_din into R0 on that clk; if coincident with a DMA increment, the load wins.
REQ-034 In CPU and INT states, ram_a SHALL be 0 and ram_rd 0.

Reset
REQ-035 While reset=1: phase=0, state=CPU, R0=0, DataOut=0, TPA=TPB=0, ram_rd=0, cpu_hold=0, int_ack=0, SC=cpu_sc.
REQ-036 Reset asserted mid-DMA SHALL abort the cycle with no R0 increment; first cycle after release is CPU.

Verification
REQ-037 ce=1 constant, no requests -> TPA high at phases 1, 9, 17...; TPB at 6, 14, 22; SC follows cpu_sc; cpu_hold=0.
REQ-038 R0=0x0100, RAM[0x0100..0x0107]=0x11..0x88, dma_out_req held 8 cycles -> 8 DMA cycles SC=10, DataOut 0x11..0x88 in order, R0=0x0108 after.
REQ-039 dma_out_req and int_req both high with ie=1 at phase 7 -> DMA cycle first; INT after dma_out_req drops; int_ack one clk.
REQ-040 int_req=1, ie=0 -> no INT cycle, SC stays cpu_sc; int_req held with ie=1 -> INT cycles not back-to-back.
REQ-041 R0=0xFFFF, one DMA cycle -> byte from 0xFFFF output, R0=0x0000; r0_we with 0x1234 at same phase-7 edge -> R0=0x1234.
REQ-042 reset pulsed at phase 4 of a DMA cycle -> R0=0, DataOut=0, state CPU, phase 0 at release.
